// File: rtl/add_pkg.sv
// Shared constants for the add_sched arbitrated adder.
package add_pkg;

  localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/add.sv
// Signed adder: sign-extends both operands to the wider width plus one bit.
module add #(
  parameter  int unsigned L1 = 8,
  parameter  int unsigned L2 = 8,
  localparam int unsigned SW = ((L1 > L2) ? L1 : L2) + 1
) (
  input  logic signed [L1-1:0] i_a,
  input  logic signed [L2-1:0] i_b,
  output logic signed [SW-1:0] o_sum
);

  // A size cast of a signed operand sign-extends, so the sum cannot overflow.
  assign o_sum = SW'(i_a) + SW'(i_b);

endmodule

// File: rtl/add_sched.sv
// Round-robin arbiter sharing one signed adder among N requesters,
// with results queued with their source index in a 2-entry FIFO.
module add_sched
  import add_pkg::*;
#(
  parameter  int unsigned N  = 4,
  parameter  int unsigned L  = 8,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req_valid,
  input  logic [N*L-1:0]      req_a,
  input  logic [N*L-1:0]      req_b,
  output logic [N-1:0]        req_ready,
  output logic                res_valid,
  output logic signed [L:0]   res_sum,
  output logic [IW-1:0]       res_id,
  input  logic                res_ready
);

  typedef struct packed {
    logic signed [L:0] sum;
    logic [IW-1:0]     id;
  } entry_t;

  entry_t              r_mem [FIFO_DEPTH];
  logic [1:0]          r_count;
  logic                r_rd_ptr;
  logic                r_wr_ptr;
  logic [IW-1:0]       r_ptr;

  logic                w_found;
  logic [IW-1:0]       w_grant;
  logic                w_can_push;
  logic                w_push;
  logic                w_pop;
  logic signed [L-1:0] w_a;
  logic signed [L-1:0] w_b;
  logic signed [L:0]   w_sum;

  // NOTE: combinational blocks assign a default to every output first, so no
  // path leaves a value held and no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (!w_found && req_valid[IW'((int'(r_ptr) + k) % int'(N))]) begin
        w_found = 1'b1;
        w_grant = IW'((int'(r_ptr) + k) % int'(N));
      end
    end
  end

  // Full is judged on the registered count only, so a same-cycle pop never
  // opens a slot and req_ready has no path from res_ready.
  assign w_can_push = !rst && (r_count < 2'(FIFO_DEPTH));
  assign w_push     = w_found && w_can_push;
  assign w_pop      = res_valid && res_ready;

  always_comb begin
    req_ready = '0;
    if (w_push) req_ready[w_grant] = 1'b1;
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (w_grant == IW'(i)) begin
        w_a = req_a[i*L +: L];
        w_b = req_b[i*L +: L];
      end
    end
  end

  add #(.L1(L), .L2(L)) u_add (
    .i_a   (w_a),
    .i_b   (w_b),
    .o_sum (w_sum)
  );

  // NOTE: the two FIFO entries are reset so the head reads as zero after
  // reset; sequential state is always updated with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_ptr    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{sum: w_sum, id: w_grant};
        r_wr_ptr        <= ~r_wr_ptr;
        r_ptr           <= (w_grant == IW'(N - 1)) ? '0 : w_grant + 1'b1;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign res_valid = (r_count != 2'd0);
  assign res_sum   = r_mem[r_rd_ptr].sum;
  assign res_id    = r_mem[r_rd_ptr].id;

endmodule

// File: tb/tb_add_sched.sv
// Directed self-checking bench for add_sched (N=4, L=8).
module tb_add_sched;

  localparam int N  = 4;
  localparam int L  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*L-1:0] req_a;
  logic [N*L-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic [L:0]     res_sum;
  logic [IW-1:0]  res_id;
  logic           res_ready;

  int n_vec = 0;
  int n_err = 0;

  add_sched #(.N(N), .L(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_sum   (res_sum),
    .res_id    (res_id),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*L +: L] = a;
    req_b[i*L +: L] = b;
  endtask

  task automatic check_head(input string tag, input logic [8:0] sum, input logic [1:0] id);
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_sum"},   32'(res_sum),   32'(sum));
    check({tag, "_id"},    32'(res_id),    32'(id));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    tick();
    tick();
    check("rst_ready",     32'(req_ready), 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_res_sum",   32'(res_sum),   32'h0);
    check("rst_res_id",    32'(res_id),    32'h0);
    req_valid = '0;
    rst       = 1'b0;
    #1;
    check("idle_ready", 32'(req_ready), 32'h0);

    // Single sum from requester 2: 100 + 27 = 127.
    req_valid = 4'b0100;
    set_op(2, 8'd100, 8'd27);
    res_ready = 1'b1;
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    #1;
    check_head("single", 9'd127, 2'd2);

    // ptr is 3: search 3,0 grants requester 0. -128 + -128 = -256.
    req_valid = 4'b0001;
    set_op(0, 8'h80, 8'h80);
    #1;
    check("neg_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    check_head("neg_ext", 9'h100, 2'd0);

    req_valid = 4'b0010;
    set_op(1, 8'd127, 8'd127);
    #1;
    check("pos_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    #1;
    check_head("pos_ext", 9'd254, 2'd1);
    tick();
    check("drained", 32'(res_valid), 32'h0);

    // Fairness: all valid, consumer always ready, grants rotate 0,1,2,3,0,1.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 8'(i * 10), 8'd1);
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      tick();
      check_head($sformatf("rr%0d", k), 9'((k % 4) * 10 + 1), 2'(k % 4));
    end
    req_valid = '0;
    tick();

    // Backpressure: requesters 0 and 3, consumer stalled.
    do_reset();
    res_ready = 1'b0;
    set_op(0, 8'd5, 8'd5);
    set_op(3, 8'hFD, 8'hFC);
    req_valid = 4'b1001;
    #1;
    check("bp_ready0", 32'(req_ready), 32'h1);
    tick();
    check("bp_ready1", 32'(req_ready), 32'h8);
    check_head("bp_head0", 9'd10, 2'd0);
    tick();
    check("bp_full_ready", 32'(req_ready), 32'h0);
    check_head("bp_full_head", 9'd10, 2'd0);
    tick();
    check("bp_stall_ready", 32'(req_ready), 32'h0);
    check_head("bp_stall_head", 9'd10, 2'd0);

    // Full with simultaneous pop: no accept this cycle.
    res_ready = 1'b1;
    #1;
    check("fullpop_ready", 32'(req_ready), 32'h0);
    tick();
    res_ready = 1'b0;
    #1;
    check_head("after_pop", 9'h1F9, 2'd3);
    check("resume_ready", 32'(req_ready), 32'h1);
    tick();
    check("refull_ready", 32'(req_ready), 32'h0);
    check_head("refull_head", 9'h1F9, 2'd3);

    // Reset with two entries queued discards them and rewinds ptr.
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = '0;
    #1;
    check("mid_rst_valid", 32'(res_valid), 32'h0);
    check("mid_rst_sum",   32'(res_sum),   32'h0);
    check("mid_rst_id",    32'(res_id),    32'h0);
    set_op(0, 8'd20, 8'd1);
    req_valid = 4'b1111;
    res_ready = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    check_head("post_rst", 9'd21, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
